// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 timing constants, coordinate width and monitor state shared by the VGA timing monitor
package vga_pkg;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W = 11;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} mon_state_e;
endpackage

// File: rtl/vga_crc24_step.sv
// vga_crc24_step: combinational CRC-16-CCITT update folding 24 data bits, MSB (red) first
module vga_crc24_step
  import vga_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [23:0] data,
  output logic [15:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 23; i >= 0; i--)
      crc_out = {crc_out[14:0], 1'b0} ^ ((crc_out[15] ^ data[i]) ? CRC_POLY : 16'h0);
  end
endmodule

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: recovers VGA active-pixel coordinates, checks line/frame timing for lock and samples a probe pixel
// Defining VGA_MONITOR_CRC_EN adds frame_crc, a CRC-16-CCITT over each frame's active rgb bytes.
module vga_timing_monitor
  import vga_pkg::*;
#(
  parameter int H_TOTAL = vga_pkg::H_TOTAL,
  parameter int V_TOTAL = vga_pkg::V_TOTAL,
  parameter int LOCK_FRAMES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               blank,
  input  logic [23:0]        rgb,
  input  logic [COORD_W-1:0] probex,
  input  logic [COORD_W-1:0] probey,
  output logic [COORD_W-1:0] pixelx,
  output logic [COORD_W-1:0] pixely,
  output logic [COORD_W-1:0] line_len,
  output logic [COORD_W-1:0] frame_lines,
  output logic               locked,
  output logic               sync_err,
  output logic [23:0]        probe_color,
  output logic               probe_valid
`ifdef VGA_MONITOR_CRC_EN
  ,
  output logic [15:0]        frame_crc
`endif
);
  localparam logic [COORD_W-1:0] CMAX = '1;
  logic hs_q, vs_q, blank_q, hs_d, vs_d;
  logic [23:0] rgb_q;
  logic [COORD_W-1:0] hcnt, vcnt, sx, sy, lines_now;
  logic act, line_bad, hs_fall, vs_fall, hs_bad, frame_good, wdog, match;
  logic [7:0] good_cnt;
  mon_state_e state;

  always_comb begin
    hs_fall = hs_d & ~hs_q;
    vs_fall = vs_d & ~vs_q;
    hs_bad = hs_fall && hcnt != COORD_W'(H_TOTAL);
    lines_now = vcnt + COORD_W'(hs_fall);
    frame_good = !line_bad && !hs_bad && lines_now == COORD_W'(V_TOTAL);
    wdog = hcnt == CMAX;
    match = blank_q && pixelx == sx && pixely == sy;
  end

  // act remembers whether the current line has shown any active pixel, for pixely
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {hs_q, vs_q, blank_q, hs_d, vs_d, act, line_bad, probe_valid} <= '0;
      rgb_q <= '0;
      probe_color <= '0;
      {hcnt, vcnt, sx, sy, pixelx, pixely, line_len, frame_lines} <= '0;
    end else begin
      {hs_q, vs_q, blank_q, rgb_q} <= {hsync, vsync, blank, rgb};
      {hs_d, vs_d} <= {hs_q, vs_q};
      hcnt <= hs_fall ? COORD_W'(1) : wdog ? hcnt : hcnt + 1'b1;
      if (hs_fall) line_len <= hcnt;
      vcnt <= vs_fall ? '0 : lines_now;
      if (vs_fall) {frame_lines, sx, sy} <= {lines_now, probex, probey};
      pixelx <= hs_fall ? '0 : pixelx + COORD_W'(blank_q);
      act <= !hs_fall && (act || blank_q);
      pixely <= vs_fall ? '0 : pixely + COORD_W'(hs_fall && (act || blank_q));
      line_bad <= !vs_fall && (line_bad || (hs_bad && state != SEARCH));
      probe_valid <= match;
      if (match) probe_color <= rgb_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEARCH;
      good_cnt <= '0;
      locked <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      case (state)
        SEARCH: if (vs_fall) begin
          state <= MEASURE;
          good_cnt <= '0;
        end
        MEASURE: if (wdog) state <= SEARCH;
          else if (vs_fall) begin
            if (!frame_good) good_cnt <= '0;
            else if (good_cnt + 8'd1 >= 8'(LOCK_FRAMES)) begin
              state <= LOCKED;
              locked <= 1'b1;
            end else good_cnt <= good_cnt + 8'd1;
          end
        LOCKED: if (wdog || hs_bad || (vs_fall && !frame_good)) begin
          state <= SEARCH;
          locked <= 1'b0;
          sync_err <= 1'b1;
        end
        default: begin
          state <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_MONITOR_CRC_EN
  logic [15:0] crc_acc, crc_nxt;

  vga_crc24_step u_crc (
    .crc_in (crc_acc),
    .data   (rgb_q),
    .crc_out(crc_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_acc <= 16'hFFFF;
      frame_crc <= '0;
    end else if (vs_fall) begin
      frame_crc <= crc_acc;
      crc_acc <= 16'hFFFF;
    end else if (blank_q) crc_acc <= crc_nxt;
  end
`endif
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: frame-level directed checks of vga_timing_monitor on a scaled 100x20 raster (64x12 active)
`timescale 1ns/1ps
module tb_vga_timing_monitor;
  localparam int H = 100, V = 20, HA = 64, VA = 12, HS0 = 70, HS1 = 80, VS0 = 15;
  logic clk = 0, rst = 0, hsync = 1, vsync = 1, blank = 0;
  logic [23:0] rgb = 0;
  logic [10:0] probex = 0, probey = 0;
  logic [10:0] pixelx, pixely, line_len, frame_lines;
  logic locked, sync_err, probe_valid;
  logic [23:0] probe_color;
`ifdef VGA_MONITOR_CRC_EN
  logic [15:0] frame_crc;
`endif
  int checks = 0, errors = 0;
  int n = 0, rise_n = 0, pv_cnt = 0, se_cnt = 0, cx = -1, cy = -1;
  bit pat = 1, sim = 0;
  int sp_x = 10, sp_y = 5, short_y = -1;
  logic [23:0] sp_rgb = 24'hFF00AA;
  logic locked_prev = 0;

  typedef struct {
    int px, py, sy;
    bit sm;
    logic lk;
    int fl, pv;
    logic [23:0] col;
    int se;
  } vec_t;
  vec_t tbl [11];

  vga_timing_monitor #(.H_TOTAL(H), .V_TOTAL(V), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .blank(blank), .rgb(rgb),
    .probex(probex), .probey(probey), .pixelx(pixelx), .pixely(pixely),
    .line_len(line_len), .frame_lines(frame_lines), .locked(locked),
    .sync_err(sync_err), .probe_color(probe_color), .probe_valid(probe_valid)
`ifdef VGA_MONITOR_CRC_EN
    , .frame_crc(frame_crc)
`endif
  );

  always #20 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pix(input logic hs, input logic vs, input logic bl, input logic [23:0] c);
    hsync = hs;
    vsync = vs;
    blank = bl;
    rgb = c;
    @(posedge clk);
    #1;
    n++;
    if (locked && !locked_prev && rise_n == 0) rise_n = n;
    locked_prev = locked;
    pv_cnt += int'(probe_valid);
    se_cnt += int'(sync_err);
  endtask

  function automatic logic [23:0] pix_rgb(input int x, input int y);
    if (x == sp_x && y == sp_y) return sp_rgb;
    return pat ? {8'(x), 8'(y), 8'h11} : 24'h0;
  endfunction

  function automatic logic vs_low(input int x, input int y);
    if (sim) return (y == VS0 - 1 && x >= HS0) || y == VS0 || (y == VS0 + 1 && x < HS0);
    return y == VS0 || y == VS0 + 1;
  endfunction

  task automatic line(input int y);
    for (int x = 0; x < (y == short_y ? H - 1 : H); x++) begin
      pix(!(x >= HS0 && x < HS1), !vs_low(x, y), x < HA && y < VA,
          (x < HA && y < VA) ? pix_rgb(x, y) : 24'h0);
      if (y == 5 && x == 10) begin
        cx = int'(pixelx);
        cy = int'(pixely);
      end
    end
  endtask

  task automatic frame();
    for (int y = 0; y < V; y++) line(y);
  endtask

`ifdef VGA_MONITOR_CRC_EN
  function automatic logic [15:0] crc_model();
    logic [15:0] c = 16'hFFFF;
    logic [23:0] p;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++) begin
        p = pix_rgb(x, y);
        for (int b = 2; b >= 0; b--) begin
          c = c ^ {p[b*8 +: 8], 8'h00};
          for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
      end
    return c;
  endfunction
`endif

  initial begin
    int k;
`ifdef VGA_MONITOR_CRC_EN
    logic [15:0] c0, c1;
`endif
    tbl[0]  = '{10, 5, -1, 0, 1'b0, 15, 1, 24'h000011, 0};
    tbl[1]  = '{10, 5, -1, 0, 1'b0, 20, 1, 24'hFF00AA, 0};
    tbl[2]  = '{10, 5, -1, 0, 1'b1, 20, 1, 24'hFF00AA, 0};
    tbl[3]  = '{70, 5, -1, 0, 1'b1, 20, 1, 24'hFF00AA, 0};
    tbl[4]  = '{70, 5, -1, 0, 1'b1, 20, 0, 24'hFF00AA, 0};
    tbl[5]  = '{10, 5,  3, 0, 1'b0, 20, 0, 24'hFF00AA, 1};
    tbl[6]  = '{10, 5, -1, 0, 1'b0, 20, 1, 24'hFF00AA, 0};
    tbl[7]  = '{10, 5, -1, 0, 1'b1, 20, 1, 24'hFF00AA, 0};
    tbl[8]  = '{10, 5, -1, 1, 1'b1, 20, 1, 24'hFF00AA, 0};
    tbl[9]  = '{10, 5, -1, 1, 1'b1, 20, 1, 24'hFF00AA, 0};
    tbl[10] = '{10, 5, -1, 0, 1'b1, 20, 1, 24'hFF00AA, 0};
    probex = 11'd10;
    probey = 11'd5;
    repeat (3) @(posedge clk);
    #1;
    check("reset_counts", 64'({pixelx, pixely, line_len, frame_lines}), 64'(0));
    check("reset_flags", 64'({locked, sync_err, probe_valid, probe_color}), 64'(0));
    rst = 1;
    for (int i = 0; i < 11; i++) begin
      probex = 11'(tbl[i].px);
      probey = 11'(tbl[i].py);
      short_y = tbl[i].sy;
      sim = tbl[i].sm;
      pv_cnt = 0;
      se_cnt = 0;
      frame();
      check($sformatf("locked[%0d]", i), 64'(locked), 64'(tbl[i].lk));
      check($sformatf("frame_lines[%0d]", i), 64'(frame_lines), 64'(tbl[i].fl));
      check($sformatf("line_len[%0d]", i), 64'(line_len), 64'(H));
      check($sformatf("probe_pulses[%0d]", i), 64'(pv_cnt), 64'(tbl[i].pv));
      check($sformatf("probe_color[%0d]", i), 64'(probe_color), 64'(tbl[i].col));
      check($sformatf("sync_err_pulses[%0d]", i), 64'(se_cnt), 64'(tbl[i].se));
      check($sformatf("pixelx_at_10_5[%0d]", i), 64'(cx), 64'(10));
      check($sformatf("pixely_at_10_5[%0d]", i), 64'(cy), 64'(5));
    end
    check("lock_rise_cycle", 64'(rise_n), 64'(2 * V * H + VS0 * H + 2));
    k = 0;
    while (!sync_err && k < 2200) begin
      pix(1, 1, 0, 24'h0);
      k++;
    end
    check("wdog_cycles", 64'(k), 64'(2019));
    check("wdog_locked", 64'(locked), 64'(0));
    pix(1, 1, 0, 24'h0);
    check("wdog_one_pulse", 64'(sync_err), 64'(0));
    for (int y = 0; y < 5; y++) line(y);
    for (int x = 0; x <= 30; x++) pix(1, 1, 1, pix_rgb(x, 5));
    check("pre_reset_pixelx", 64'(pixelx), 64'(30));
    #5;
    rst = 0;
    #1;
    check("async_reset_counts", 64'({pixelx, pixely, line_len, frame_lines}), 64'(0));
    check("async_reset_flags", 64'({locked, sync_err, probe_valid, probe_color}), 64'(0));
    #3;
    rst = 1;
    frame();
    frame();
    check("relock_not_yet", 64'(locked), 64'(0));
    frame();
    check("relock", 64'(locked), 64'(1));
`ifdef VGA_MONITOR_CRC_EN
    pat = 0;
    sp_x = 3;
    sp_y = 2;
    sp_rgb = 24'h000000;
    frame();
    check("crc_black", 64'(frame_crc), 64'(crc_model()));
    c0 = frame_crc;
    sp_rgb = 24'h000001;
    frame();
    check("crc_one_pixel", 64'(frame_crc), 64'(crc_model()));
    check("crc_differs", 64'(frame_crc != c0), 64'(1));
    c1 = frame_crc;
    frame();
    check("crc_repeat", 64'(frame_crc), 64'(c1));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
